// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-requester ALU scheduler:
//   - data / shift / opcode widths
//   - opcode constants (ADD..SRA); any other opcode value is illegal
//   - scheduler FSM state encoding
//   - command and response record types
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 5;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd3;
  localparam logic [OPC_W-1:0] OP_SLL = 4'd4;
  localparam logic [OPC_W-1:0] OP_SRA = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Accepted command, held in the operand registers while the op executes.
  typedef struct packed {
    logic               id;
    logic [OPC_W-1:0]   opcode;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [SHAMT_W-1:0] shamt;
  } alu_cmd_t;

  // Registered response payload, stable for the whole RESP phase.
  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              ovf;
    logic              sign;
    logic              err;
  } alu_rsp_t;

endpackage

// File: rtl/alu16_core.sv
// -----------------------------------------------------------------------------
// alu16_core
// Purely combinational 16-bit ALU.
//   opcode  : operation select (ADD, SUB, AND, OR, SLL, SRA; others illegal)
//   a, b    : operands
//   shamt   : shift amount for SLL/SRA (16..31 saturates)
//   result  : 16-bit result (0 for illegal opcodes)
//   carry   : ADD carry-out / SUB borrow, 0 otherwise
//   zero    : result == 0
//   ovf     : signed overflow for ADD/SUB, 0 otherwise
//   sign    : result[15]
//   err     : illegal opcode
// -----------------------------------------------------------------------------
module alu16_core
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]   opcode,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               carry,
  output logic               zero,
  output logic               ovf,
  output logic               sign,
  output logic               err
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            shift_big;

  // One extra bit on both paths: sum[16] is carry-out, diff[16] is the
  // unsigned borrow (a < b).
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign shift_big = shamt[SHAMT_W-1];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SLL: result = shift_big ? '0 : (a << shamt[SHAMT_W-2:0]);
      OP_SRA: result = shift_big ? {DATA_W{a[DATA_W-1]}}
                                 : DATA_W'($signed(a) >>> shamt[SHAMT_W-2:0]);
      default: err = 1'b1;
    endcase
  end

  assign zero = (result == '0);
  assign sign = result[DATA_W-1];

endmodule

// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
// Two requesters share one ALU. A round-robin arbiter grants one command at a
// time; each op walks IDLE -> EXEC -> RESP -> IDLE, so at most one op is in
// flight and the response is held until the consumer takes it.
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid / reqN_ready    : command handshake for requester N (0,1)
//   reqN_opcode/a/b/shamt      : command payload for requester N
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id                     : requester that issued the response
//   rsp_result + flags, rsp_err: registered ALU result
// -----------------------------------------------------------------------------
module alu_rr_scheduler
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [OPC_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [OPC_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,

  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_ovf,
  output logic               rsp_sign,
  output logic               rsp_err
);

  state_e   state_q,     state_d;
  logic     last_q,      last_d;       // requester granted most recently
  alu_cmd_t cmd_q,       cmd_d;        // operand registers
  alu_rsp_t rsp_q,       rsp_d;        // response registers
  logic     rsp_valid_q, rsp_valid_d;

  alu_cmd_t req0_cmd, req1_cmd;
  alu_rsp_t alu_out;
  logic     gnt_vld, gnt_id, accept;

  assign req0_cmd = '{id: 1'b0, opcode: req0_opcode, a: req0_a, b: req0_b, shamt: req0_shamt};
  assign req1_cmd = '{id: 1'b1, opcode: req1_opcode, a: req1_a, b: req1_b, shamt: req1_shamt};

  // ---------------------------------------------------------------------------
  // Round-robin grant: a lone requester always wins; under contention the one
  // not granted last wins. last_q resets to 1 so req0 wins the first tie.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    else                          gnt_id = ~req0_valid;
  end

  // Ready is purely combinational and gated by rst_n so nothing is offered
  // while reset is held, even though the state already reads IDLE.
  assign req0_ready = rst_n & (state_q == ST_IDLE) & gnt_vld & ~gnt_id;
  assign req1_ready = rst_n & (state_q == ST_IDLE) & gnt_vld &  gnt_id;
  assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);

  alu16_core u_core (
    .opcode (cmd_q.opcode),
    .a      (cmd_q.a),
    .b      (cmd_q.b),
    .shamt  (cmd_q.shamt),
    .result (alu_out.result),
    .carry  (alu_out.carry),
    .zero   (alu_out.zero),
    .ovf    (alu_out.ovf),
    .sign   (alu_out.sign),
    .err    (alu_out.err)
  );
  assign alu_out.id = cmd_q.id;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d   = gnt_id ? req1_cmd : req0_cmd;
          last_d  = gnt_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_d       = alu_out;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Payload is left untouched here so it stays stable across stalls.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Reset also discards any op in EXEC/RESP: its response is never shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_carry  = rsp_q.carry;
  assign rsp_zero   = rsp_q.zero;
  assign rsp_ovf    = rsp_q.ovf;
  assign rsp_sign   = rsp_q.sign;
  assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Self-checking bench: directed scenarios plus randomized ops, compared to an
// arithmetic reference model. Inputs change on the falling edge, outputs are
// sampled on the falling edge (or 1ns after an input change for ready).
// -----------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode = '0, req1_opcode = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_shamt = '0, req1_shamt = '0;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_ovf, rsp_sign, rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_sign(rsp_sign), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: {result[15:0], carry, zero, ovf, sign, err}
  function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [4:0] sh);
    int ua, ub, sa, sb, r, s;
    logic c, o, e;
    ua = int'(a); ub = int'(b);
    sa = a[15] ? ua - 65536 : ua;
    sb = b[15] ? ub - 65536 : ub;
    c = 1'b0; o = 1'b0; e = 1'b0; r = 0;
    case (op)
      4'd0: begin s = ua + ub; r = s % 65536; c = (s > 65535);
                  o = ((sa + sb) > 32767) || ((sa + sb) < -32768); end
      4'd1: begin r = (ua - ub + 65536) % 65536; c = (ua < ub);
                  o = ((sa - sb) > 32767) || ((sa - sb) < -32768); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = (sh >= 16) ? 0 : ((ua << sh) % 65536);
      4'd5: r = (sh >= 16) ? (a[15] ? 65535 : 0) : ((sa >>> sh) & 65535);
      default: e = 1'b1;
    endcase
    return {r[15:0], c, (r[15:0] == 16'h0), o, r[15], e};
  endfunction

  function automatic logic [20:0] observed();
    return {rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_sign, rsp_err};
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [4:0] sh);
    if (id == 0) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_shamt = sh;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_shamt = sh;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one op to completion. edges counts rising edges from the accept
  // edge (1) to the edge after which rsp_valid is first seen.
  task automatic do_op(input int id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] sh,
                       output logic to, output int edges, output logic [20:0] obs,
                       output logic rid);
    to = 1'b0; edges = 0; obs = '0; rid = 1'b0;
    @(negedge clk);
    set_req(id, 1'b1, op, a, b, sh);
    #1;
    for (int n = 0; n < 20 && !rdy(id); n++) begin @(negedge clk); #1; end
    if (!rdy(id)) begin to = 1'b1; set_req(id, 1'b0, op, a, b, sh); return; end
    @(posedge clk); edges = 1;
    @(negedge clk);
    set_req(id, 1'b0, op, a, b, sh);
    while (!rsp_valid && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
    if (!rsp_valid) begin to = 1'b1; return; end
    obs = observed(); rid = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_handshake got %b want 000", {req0_ready, req1_ready, rsp_valid});
    end
    checks++;
    if ({rsp_id, observed()} !== 22'h0) begin
      errors++; $display("FAIL reset_payload got %h want 0", {rsp_id, observed()});
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL first_contention got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_add_wrap();
    logic to, rid; int edges; logic [20:0] obs;
    do_op(0, 4'd0, 16'hFFFF, 16'h0001, 5'd0, to, edges, obs, rid);
    checks++;
    if (to !== 1'b0 || edges != 2) begin
      errors++; $display("FAIL add_latency got to=%b edges=%0d want to=0 edges=2", to, edges);
    end
    checks++;
    if ({rid, obs} !== {1'b0, 16'h0000, 5'b11000}) begin
      errors++; $display("FAIL add_wrap got %h want %h", {rid, obs}, {1'b0, 16'h0000, 5'b11000});
    end
  endtask

  task automatic test_sub_shift();
    logic to, rid; int edges; logic [20:0] obs;
    do_op(1, 4'd1, 16'h8000, 16'h0001, 5'd0, to, edges, obs, rid);
    checks++;
    if (to !== 1'b0 || {rid, obs} !== {1'b1, 16'h7FFF, 5'b00100}) begin
      errors++; $display("FAIL sub_ovf got to=%b %h want %h", to, {rid, obs}, {1'b1, 16'h7FFF, 5'b00100});
    end
    do_op(0, 4'd5, 16'h8000, 16'h1234, 5'd20, to, edges, obs, rid);
    checks++;
    if (to !== 1'b0 || obs !== {16'hFFFF, 5'b00010}) begin
      errors++; $display("FAIL sra_big got to=%b %h want %h", to, obs, {16'hFFFF, 5'b00010});
    end
    do_op(1, 4'd4, 16'h0001, 16'h0000, 5'd15, to, edges, obs, rid);
    checks++;
    if (to !== 1'b0 || obs !== {16'h8000, 5'b00010}) begin
      errors++; $display("FAIL sll_15 got to=%b %h want %h", to, obs, {16'h8000, 5'b00010});
    end
    do_op(0, 4'd4, 16'hFFFF, 16'h0000, 5'd16, to, edges, obs, rid);
    checks++;
    if (to !== 1'b0 || obs !== {16'h0000, 5'b01000}) begin
      errors++; $display("FAIL sll_16 got to=%b %h want %h", to, obs, {16'h0000, 5'b01000});
    end
  endtask

  task automatic test_illegal();
    logic to, rid; int edges; logic [20:0] obs;
    do_op(0, 4'd9, 16'h1357, 16'h2468, 5'd3, to, edges, obs, rid);
    checks++;
    if (to !== 1'b0 || obs !== {16'h0000, 5'b01001}) begin
      errors++; $display("FAIL illegal_op got to=%b %h want %h", to, obs, {16'h0000, 5'b01001});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op[2]; logic [15:0] a[2], b[2]; logic [4:0] sh[2];
    int ids[$]; int times[$]; logic [20:0] pays[$];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      op[i] = 4'($urandom_range(0, 5)); a[i] = 16'($urandom); b[i] = 16'($urandom);
      sh[i] = 5'($urandom);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 1'b1, op[0], a[0], b[0], sh[0]);
    set_req(1, 1'b1, op[1], a[1], b[1], sh[1]);
    for (int n = 0; n < 30 && ids.size() < 4; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ids.push_back(int'(rsp_id)); times.push_back(cyc); pays.push_back(observed()); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (ids.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d want 4", ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ids[i] != (i % 2)) begin
          errors++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, ids[i], i % 2);
        end
        checks++;
        if (pays[i] !== model(op[i%2], a[i%2], b[i%2], sh[i%2])) begin
          errors++; $display("FAIL b2b_payload[%0d] got %h want %h", i, pays[i], model(op[i%2], a[i%2], b[i%2], sh[i%2]));
        end
        if (i > 0) begin
          checks++;
          if (times[i] - times[i-1] != 3) begin
            errors++; $display("FAIL b2b_spacing[%0d] got %0d want 3", i, times[i] - times[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [20:0] snap; logic [15:0] a0, b1; logic to;
    a0 = 16'($urandom); b1 = 16'($urandom);
    @(negedge clk);
    set_req(0, 1'b1, 4'd0, a0, 16'h0101, 5'd0);
    #1;
    to = 1'b0;
    for (int n = 0; n < 20 && !req0_ready; n++) begin @(negedge clk); #1; end
    if (!req0_ready) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    set_req(1, 1'b1, 4'd3, 16'h00F0, b1, 5'd0);
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    snap = observed();
    checks++;
    if (to || !rsp_valid || snap !== model(4'd0, a0, 16'h0101, 5'd0) || rsp_id !== 1'b0) begin
      errors++; $display("FAIL stall_first got to=%b v=%b %h want %h", to, rsp_valid, snap, model(4'd0, a0, 16'h0101, 5'd0));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b100 || observed() !== snap) begin
        errors++; $display("FAIL stall_hold[%0d] got v/r0/r1=%b %h want 100 %h", i,
                           {rsp_valid, req0_ready, req1_ready}, observed(), snap);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; #1;
    checks++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_resume got v/r1=%b want 01", {rsp_valid, req1_ready});
    end
    @(negedge clk);
    req1_valid = 1'b0;
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    checks++;
    if (!rsp_valid || rsp_id !== 1'b1 || observed() !== model(4'd3, 16'h00F0, b1, 5'd0)) begin
      errors++; $display("FAIL stall_second got v=%b id=%b %h want %h", rsp_valid, rsp_id, observed(), model(4'd3, 16'h00F0, b1, 5'd0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic to, rid, seen; int edges; logic [20:0] obs;
    // Leave req0 as last winner so a surviving pointer would favour req1.
    do_op(0, 4'd2, 16'hF0F0, 16'hFF00, 5'd0, to, edges, obs, rid);
    @(negedge clk);
    set_req(0, 1'b1, 4'd0, 16'h0001, 16'h0002, 5'd0);
    #1;
    for (int n = 0; n < 20 && !req0_ready; n++) begin @(negedge clk); #1; end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0; #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_rsp got rsp_valid seen=%b want 0", seen);
    end
    set_req(0, 1'b1, 4'd1, 16'h0005, 16'h0003, 5'd0);
    set_req(1, 1'b1, 4'd3, 16'h0005, 16'h0003, 5'd0);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL abort_regrant got %b want 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    checks++;
    if (!rsp_valid || rsp_id !== 1'b0 || observed() !== {16'h0002, 5'b00000}) begin
      errors++; $display("FAIL abort_next_op got v=%b id=%b %h want 1 0 %h", rsp_valid, rsp_id, observed(), {16'h0002, 5'b00000});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic to, rid; int edges; logic [20:0] obs, exp;
    int id; logic [3:0] op; logic [15:0] a, b; logic [4:0] sh;
    for (int i = 0; i < 40; i++) begin
      id = int'($urandom_range(0, 1));
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      a = 16'($urandom); b = 16'($urandom); sh = 5'($urandom);
      if (i % 5 == 0) b = a;
      exp = model(op, a, b, sh);
      do_op(id, op, a, b, sh, to, edges, obs, rid);
      checks++;
      if (to || edges != 2 || rid !== 1'(id) || obs !== exp) begin
        errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h sh=%0d got to=%b e=%0d id=%b %h want e=2 id=%0d %h",
                           i, op, a, b, sh, to, edges, rid, obs, id, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_shift();
    test_illegal();
    test_back_to_back();
    test_stall();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
